// File: rtl/simd_addsub_pipe.sv
// simd_addsub_pipe: two-stage SIMD adder/subtractor with per-lane flags.
// Stage 1 adds the low half; stage 2 adds the high half, then flags and clamps.
module simd_addsub_pipe #(
    parameter int WIDTH    = 64,
    parameter int LANE_MIN = 8,
    localparam int NCHUNK  = WIDTH / LANE_MIN,
    localparam int MODE_W  = $clog2(NCHUNK) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [MODE_W-1:0] mode,
    input  logic [NCHUNK-1:0] sub,
    input  logic              sat_en,
    input  logic              sat_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [NCHUNK-1:0] cflag,
    output logic [NCHUNK-1:0] vflag
);

    localparam int HALF = WIDTH / 2;
    localparam int HCH  = NCHUNK / 2;
    localparam int LOG  = $clog2(NCHUNK);
    localparam int L    = LANE_MIN;

    // Chunk-index mask of one lane: (chunks per lane) - 1
    function automatic int lane_msk(input logic [MODE_W-1:0] m);
        int me;
        me = (int'(m) > LOG) ? LOG : int'(m);
        return (NCHUNK >> me) - 1;
    endfunction

    logic adv;

    logic              s1_valid;
    logic [HALF-1:0]   s1_lo_sum;
    logic [HALF-1:0]   s1_a_hi;
    logic [HALF-1:0]   s1_b_hi;
    logic [HCH-1:0]    s1_lo_c;
    logic [HCH-1:0]    s1_lo_v;
    logic [HCH-1:0]    s1_lo_as;
    logic [MODE_W-1:0] s1_mode;
    logic [NCHUNK-1:0] s1_sub;
    logic              s1_sat_en;
    logic              s1_sat_signed;

    logic [HALF-1:0]   lo_sum_d;
    logic [HCH-1:0]    lo_c_d;
    logic [HCH-1:0]    lo_v_d;
    logic [HCH-1:0]    lo_as_d;

    logic [WIDTH-1:0]  res_d;
    logic [NCHUNK-1:0] cf_d;
    logic [NCHUNK-1:0] vf_d;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin : s1_comb
        int mk;
        logic cy;
        logic s_l;
        logic cin;
        logic [L-1:0] ac;
        logic [L-1:0] bc;
        logic [L:0] ext;
        mk       = lane_msk(mode);
        cy       = 1'b0;
        s_l      = 1'b0;
        cin      = 1'b0;
        ac       = '0;
        bc       = '0;
        ext      = '0;
        lo_sum_d = '0;
        lo_c_d   = '0;
        lo_v_d   = '0;
        lo_as_d  = '0;
        for (int i = 0; i < HCH; i++) begin
            s_l = sub[i & ~mk];
            ac  = a[i*L +: L];
            bc  = b[i*L +: L] ^ {L{s_l}};
            cin = ((i & mk) == 0) ? s_l : cy;
            ext = {1'b0, ac} + {1'b0, bc} + {{L{1'b0}}, cin};
            cy  = ext[L];
            lo_sum_d[i*L +: L] = ext[L-1:0];
            lo_c_d[i]  = cy;
            lo_v_d[i]  = (ac[L-1] == bc[L-1]) && (ext[L-1] != ac[L-1]);
            lo_as_d[i] = ac[L-1];
        end
    end

    always_comb begin : s2_comb
        int mk;
        int t;
        logic cy;
        logic s_l;
        logic cin;
        logic top;
        logic as_t;
        logic [L-1:0] ac;
        logic [L-1:0] bc;
        logic [L-1:0] ch;
        logic [L:0] ext;
        logic [WIDTH-1:0] sum_all;
        logic [NCHUNK-1:0] c_all;
        logic [NCHUNK-1:0] v_all;
        logic [NCHUNK-1:0] as_all;
        mk      = lane_msk(s1_mode);
        t       = 0;
        s_l     = 1'b0;
        cin     = 1'b0;
        top     = 1'b0;
        as_t    = 1'b0;
        ac      = '0;
        bc      = '0;
        ch      = '0;
        ext     = '0;
        res_d   = '0;
        cf_d    = '0;
        vf_d    = '0;
        sum_all = {{HALF{1'b0}}, s1_lo_sum};
        c_all   = {{HCH{1'b0}}, s1_lo_c};
        v_all   = {{HCH{1'b0}}, s1_lo_v};
        as_all  = {{HCH{1'b0}}, s1_lo_as};
        // Midpoint carry only survives when chunk HCH is not a lane start
        cy      = s1_lo_c[HCH-1];
        for (int i = HCH; i < NCHUNK; i++) begin
            s_l = s1_sub[i & ~mk];
            ac  = s1_a_hi[(i-HCH)*L +: L];
            bc  = s1_b_hi[(i-HCH)*L +: L] ^ {L{s_l}};
            cin = ((i & mk) == 0) ? s_l : cy;
            ext = {1'b0, ac} + {1'b0, bc} + {{L{1'b0}}, cin};
            cy  = ext[L];
            sum_all[i*L +: L] = ext[L-1:0];
            c_all[i]  = cy;
            v_all[i]  = (ac[L-1] == bc[L-1]) && (ext[L-1] != ac[L-1]);
            as_all[i] = ac[L-1];
        end
        for (int i = 0; i < NCHUNK; i++) begin
            t    = i | mk;
            s_l  = s1_sub[i & ~mk];
            top  = (i == t);
            as_t = as_all[t];
            ch   = sum_all[i*L +: L];
            if (s1_sat_en && s1_sat_signed && v_all[t])
                ch = top ? {as_t, {(L-1){~as_t}}} : {L{~as_t}};
            else if (s1_sat_en && !s1_sat_signed && (c_all[t] ^ s_l))
                ch = s_l ? '0 : '1;
            res_d[i*L +: L] = ch;
            cf_d[i] = top && (c_all[i] ^ s_l);
            vf_d[i] = top && v_all[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_lo_sum     <= '0;
            s1_a_hi       <= '0;
            s1_b_hi       <= '0;
            s1_lo_c       <= '0;
            s1_lo_v       <= '0;
            s1_lo_as      <= '0;
            s1_mode       <= '0;
            s1_sub        <= '0;
            s1_sat_en     <= 1'b0;
            s1_sat_signed <= 1'b0;
            out_valid     <= 1'b0;
            result        <= '0;
            cflag         <= '0;
            vflag         <= '0;
        end else if (adv) begin
            s1_valid      <= in_valid;
            s1_lo_sum     <= lo_sum_d;
            s1_a_hi       <= a[WIDTH-1:HALF];
            s1_b_hi       <= b[WIDTH-1:HALF];
            s1_lo_c       <= lo_c_d;
            s1_lo_v       <= lo_v_d;
            s1_lo_as      <= lo_as_d;
            s1_mode       <= mode;
            s1_sub        <= sub;
            s1_sat_en     <= sat_en;
            s1_sat_signed <= sat_signed;
            out_valid     <= s1_valid;
            result        <= res_d;
            cflag         <= cf_d;
            vflag         <= vf_d;
        end
    end

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// tb_simd_addsub_pipe: directed and randomized checks of simd_addsub_pipe
// against an arithmetic per-lane reference model.
module tb_simd_addsub_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  mode;
    logic [7:0]  sub;
    logic        sat_en;
    logic        sat_signed;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [7:0]  cflag;
    logic [7:0]  vflag;

    int checks;
    int failures;

    simd_addsub_pipe #(.WIDTH(64), .LANE_MIN(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .sub(sub),
        .sat_en(sat_en), .sat_signed(sat_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cflag(cflag), .vflag(vflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane-by-lane arithmetic on wide signed integers
    function automatic void model(
        input logic [63:0] ma, input logic [63:0] mb,
        input logic [3:0] mm, input logic [7:0] ms,
        input logic se, input logic ss,
        output logic [63:0] r, output logic [7:0] c, output logic [7:0] v);
        int m, lw, nl;
        logic signed [67:0] mask, half, au, bu, sa, sb, ures, sres, res;
        logic s, cy, ov;
        m = (mm > 4'd3) ? 3 : int'(mm);
        lw = 64 >> m;
        nl = 1 << m;
        mask = (68'sd1 <<< lw) - 68'sd1;
        half = 68'sd1 <<< (lw - 1);
        r = '0;
        c = '0;
        v = '0;
        for (int l = 0; l < nl; l++) begin
            au = $signed({4'b0, ma >> (l*lw)}) & mask;
            bu = $signed({4'b0, mb >> (l*lw)}) & mask;
            s  = ms[l*lw/8];
            sa = (au >= half) ? au - mask - 68'sd1 : au;
            sb = (bu >= half) ? bu - mask - 68'sd1 : bu;
            ures = s ? au - bu : au + bu;
            cy   = s ? (au < bu) : (ures > mask);
            sres = s ? sa - sb : sa + sb;
            ov   = (sres >= half) || (sres < -half);
            res  = ures & mask;
            if (se && ss && ov)
                res = (sa < 0) ? half : half - 68'sd1;
            else if (se && !ss && cy)
                res = s ? 68'sd0 : mask;
            r = r | (64'(res) << (l*lw));
            c[(l+1)*lw/8-1] = cy;
            v[(l+1)*lw/8-1] = ov;
        end
    endfunction

    task automatic drive_beat(
        input logic [63:0] ta, input logic [63:0] tb_,
        input logic [3:0] tm, input logic [7:0] ts,
        input logic se, input logic ss,
        output logic [63:0] r, output logic [7:0] c, output logic [7:0] v,
        output int lat);
        @(negedge clk);
        a = ta; b = tb_; mode = tm; sub = ts;
        sat_en = se; sat_signed = ss;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        r = result; c = cflag; v = vflag;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; mode = '0; sub = '0;
        sat_en = 1'b0; sat_signed = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, result, cflag, vflag} !== 81'd0) begin
            failures++;
            $display("FAIL reset_state got v=%b r=%h c=%h f=%h exp all 0",
                     out_valid, result, cflag, vflag);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got in_ready=%b out_valid=%b exp 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_unified();
        logic [63:0] r;
        logic [7:0] c, v;
        int lat;
        drive_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 8'h00, 0, 0, r, c, v, lat);
        checks++;
        if (r !== 64'd0 || c !== 8'h80 || v !== 8'h00 || lat != 2) begin
            failures++;
            $display("FAIL uni_add got r=%h c=%h v=%h lat=%0d exp 0/80/00/2",
                     r, c, v, lat);
        end
        drive_beat(64'd0, 64'd1, 4'd0, 8'hFF, 0, 0, r, c, v, lat);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF || c !== 8'h80 || v !== 8'h00 || lat != 2) begin
            failures++;
            $display("FAIL uni_sub got r=%h c=%h v=%h lat=%0d exp ff..ff/80/00/2",
                     r, c, v, lat);
        end
    endtask

    task automatic test_lanes();
        logic [63:0] r;
        logic [7:0] c, v;
        int lat;
        drive_beat(64'h0000_0001_FFFF_FFFF, 64'h0000_0001_0000_0001,
                   4'd1, 8'h00, 0, 0, r, c, v, lat);
        checks++;
        if (r !== 64'h0000_0002_0000_0000 || c !== 8'h08 || v !== 8'h00) begin
            failures++;
            $display("FAIL lanes32 got r=%h c=%h v=%h exp 0000000200000000/08/00",
                     r, c, v);
        end
    endtask

    task automatic test_saturation();
        logic [63:0] r;
        logic [7:0] c, v;
        int lat;
        drive_beat({8{8'h7F}}, {8{8'h01}}, 4'd3, 8'h00, 1, 1, r, c, v, lat);
        checks++;
        if (r !== {8{8'h7F}} || v !== 8'hFF || c !== 8'h00) begin
            failures++;
            $display("FAIL sat_signed got r=%h c=%h v=%h exp 7f..7f/00/ff",
                     r, c, v);
        end
        drive_beat(64'd0, {8{8'h01}}, 4'd3, 8'hFF, 1, 0, r, c, v, lat);
        checks++;
        if (r !== 64'd0 || c !== 8'hFF || v !== 8'h00) begin
            failures++;
            $display("FAIL sat_unsigned got r=%h c=%h v=%h exp 0/ff/00",
                     r, c, v);
        end
    endtask

    task automatic test_random();
        logic [63:0] r, er, ta, tb_;
        logic [7:0] c, v, ec, ev, ts;
        logic [3:0] tm;
        logic se, ss;
        int lat;
        for (int n = 0; n < 40; n++) begin
            ta  = {$urandom, $urandom};
            tb_ = {$urandom, $urandom};
            tm  = 4'($urandom_range(0, 15));
            ts  = 8'($urandom);
            se  = 1'($urandom);
            ss  = 1'($urandom);
            if (n % 4 == 0) tb_ = ~ta;
            drive_beat(ta, tb_, tm, ts, se, ss, r, c, v, lat);
            model(ta, tb_, tm, ts, se, ss, er, ec, ev);
            checks++;
            if (r !== er || c !== ec || v !== ev || lat != 2) begin
                failures++;
                $display("FAIL random#%0d m=%0d got r=%h c=%h v=%h lat=%0d exp r=%h c=%h v=%h lat=2",
                         n, tm, r, c, v, lat, er, ec, ev);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ba[10], br[10];
        logic [63:0] bb[10];
        logic [7:0] bc[10], bv[10], bs[10];
        logic [3:0] bm[10];
        logic [1:0] bsat[10];
        logic [63:0] held;
        logic stalled;
        int sent, got, cyc;
        for (int n = 0; n < 10; n++) begin
            ba[n] = {$urandom, $urandom};
            bb[n] = {$urandom, $urandom};
            bm[n] = 4'($urandom_range(0, 3));
            bs[n] = 8'($urandom);
            bsat[n] = 2'($urandom);
            model(ba[n], bb[n], bm[n], bs[n], bsat[n][0], bsat[n][1],
                  br[n], bc[n], bv[n]);
        end
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (got < 10 && cyc < 200) begin
            @(negedge clk);
            out_ready = (cyc % 3 == 0);
            in_valid  = (sent < 10);
            if (sent < 10) begin
                a = ba[sent]; b = bb[sent]; mode = bm[sent]; sub = bs[sent];
                sat_en = bsat[sent][0]; sat_signed = bsat[sent][1];
            end
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                failures++;
                $display("FAIL b2b_ready cyc=%0d got %b exp %b",
                         cyc, in_ready, !(out_valid && !out_ready));
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || result !== held) begin
                    failures++;
                    $display("FAIL b2b_hold cyc=%0d got v=%b r=%h exp 1/%h",
                             cyc, out_valid, result, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (result !== br[got] || cflag !== bc[got] || vflag !== bv[got]) begin
                    failures++;
                    $display("FAIL b2b_beat#%0d got r=%h c=%h v=%h exp r=%h c=%h v=%h",
                             got, result, cflag, vflag, br[got], bc[got], bv[got]);
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held = result;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got != 10 || sent != 10) begin
            failures++;
            $display("FAIL b2b_count got out=%0d in=%0d exp 10/10", got, sent);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_dup got out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_reset_inflight();
        logic [63:0] r, er;
        logic [7:0] c, v, ec, ev;
        int lat;
        @(negedge clk);
        a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_1111_1111_1111;
        mode = 4'd2; sub = 8'h00; sat_en = 1'b0; sat_signed = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || result !== 64'd0 || cflag !== 8'd0 || vflag !== 8'd0) begin
            failures++;
            $display("FAIL rst_flight got v=%b r=%h c=%h f=%h exp 0/0/0/0",
                     out_valid, result, cflag, vflag);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_discard got out_valid=%b exp 0", out_valid);
        end
        drive_beat(64'h8000_0000_0000_7FFF, 64'h8000_0000_0000_0001,
                   4'd1, 8'h00, 1, 1, r, c, v, lat);
        model(64'h8000_0000_0000_7FFF, 64'h8000_0000_0000_0001,
              4'd1, 8'h00, 1, 1, er, ec, ev);
        checks++;
        if (r !== er || c !== ec || v !== ev || lat != 2) begin
            failures++;
            $display("FAIL rst_after got r=%h c=%h v=%h lat=%0d exp r=%h c=%h v=%h lat=2",
                     r, c, v, lat, er, ec, ev);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_unified();
        test_lanes();
        test_saturation();
        test_random();
        test_back_to_back();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simd_addsub_pipe.md
Name: simd_addsub_pipe

Overview:
- Parametrised, 2-stage pipelined SIMD adder/subtractor; generalises the fixed 64-bit split/unified adder to WIDTH bits partitioned into power-of-two lanes (LANE_MIN up to WIDTH).
- Adds per-lane add/sub, optional signed/unsigned saturation, per-lane carry/borrow and overflow flags, and a valid/ready handshake.
- Sits in the execute stage as the shared integer/packed-add unit.

Parameters:
- WIDTH, 64, datapath width; power of two, >= 2*LANE_MIN.
- LANE_MIN, 8, narrowest lane width in bits; power of two, >= 4.
- NCHUNK (derived), WIDTH/LANE_MIN, number of minimum-width chunks.
- MODE_W (derived), clog2(NCHUNK)+1 bits, width of the mode field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- mode  in  MODE_W  lane width = WIDTH >> mode; 0 = unified, max = NCHUNK lanes of LANE_MIN
- sub  in  NCHUNK  per-chunk subtract; a lane uses the bit of its lowest chunk
- sat_en  in  1  saturate results
- sat_signed  in  1  saturation/overflow is signed (1) or unsigned (0)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  lane-wise A±B
- cflag  out  NCHUNK  carry (add) / borrow (sub, 1 when a<b unsigned), at the lane's top chunk index
- vflag  out  NCHUNK  signed overflow, at the lane's top chunk index

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, result=0, cflag=0, vflag=0, all stage valids cleared. in_ready=1 in the cycle after reset. rst has priority over every other input; an in-flight beat is discarded.
- Advance: adv = !out_valid || out_ready. in_ready = adv (combinational). Beat accepted when in_valid && in_ready.
- Both stages shift on adv. Bubbles are not collapsed. Latency is exactly 2 cycles from acceptance to out_valid with no stall; throughput is 1 beat/cycle.
- When !adv, all stage registers and outputs hold. result is stable while out_valid && !out_ready.
- Lane arithmetic: per lane, sum = a + (b ^ {sub}) + sub. Carries never cross lane boundaries. A lane with mode > max legal value is treated as mode = max.
- Stage 1 computes the lower WIDTH/2 bits and registers the chunk carry crossing the midpoint. In mode 0, that carry is fed into stage 2; in any other mode the midpoint is a lane boundary and the carry is suppressed.
- Stage 2 computes the upper WIDTH/2 bits, flags and saturation. Stage-1 operands for the upper half, plus mode/sub/sat controls, are registered alongside.
- cflag: add gives the raw carry out; sub gives the inverted carry out (borrow). Non-top-chunk bits are 0.
- vflag is the signed overflow (sign-in equal, sign-out differs, with b inverted for sub). It is computed regardless of sat_en.
- Saturation (sat_en=1):
  - Signed: overflow clamps to the lane's most positive/negative value, by the sign of a.
  - Unsigned: carry on add clamps to all-ones; borrow on sub clamps to 0.
  - Flags report the pre-saturation condition.
- Simultaneous in_valid accept and out_ready in the same cycle: the new beat enters, the old result leaves. No loss and no duplication.

Test Plan:
- mode=0, sub=0, a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, cflag[7]=1, vflag=0, out_valid exactly 2 cycles after accept.
- mode=0, sub=all ones, a=0, b=1 -> result=64'hFFFF_FFFF_FFFF_FFFF, cflag[7]=1 (borrow); midpoint carry crosses the pipeline correctly.
- mode=1, sub=8'h00, a=64'h0000_0001_FFFF_FFFF, b=64'h0000_0001_0000_0001 -> result=64'h0000_0002_0000_0000, cflag[3]=1, cflag[7]=0 (no carry into upper lane).
- mode=3, sat_en=1, sat_signed=1, every byte of a=8'h7F, b=8'h01 -> every byte of result=8'h7F, vflag=8'hFF; same with sat_signed=0, sub set, a=0, b=1 -> bytes=0, cflag=8'hFF.
- Back-to-back 10 beats with out_ready toggling 1,0,0,1... -> no beat lost or duplicated, order preserved, result stable while stalled, in_ready=0 while out_valid && !out_ready.
- Assert rst with 2 beats in flight -> next cycle out_valid=0, result=0; first post-reset beat returns after 2 cycles.
